// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage for iterative AES-128.
// Round keys are expanded on the fly, forward or inverse.
module add_round_key_stage #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [KW-1:0] key_in,
  input  logic          dec,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] out_data,
  output logic [3:0]    round,
  output logic          last_round
);

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [KW-1:0] base_key;
  logic [KW-1:0] cur_key;
  logic [KW-1:0] nxt_key;
  logic          dec_q;
  logic          accept;
  logic [31:0]   k0, k1, k2, k3;
  logic [31:0]   rot_src, mix;
  logic [3:0]    rc_idx;

  assign in_ready = !key_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Both directions share one SubWord; only its source word differs.
  always_comb begin
    k0      = cur_key[127:96];
    k1      = cur_key[95:64];
    k2      = cur_key[63:32];
    k3      = cur_key[31:0];
    rot_src = dec_q ? (k3 ^ k2) : k3;
    rc_idx  = dec_q ? (LAST - round) : (round + 4'd1);
    mix     = k0 ^ sub_word(rot_word(rot_src))
            ^ {rcon(rc_idx), 24'h0};
    if (dec_q)
      nxt_key = {mix, k1 ^ k0, k2 ^ k1, k3 ^ k2};
    else
      nxt_key = {mix, mix ^ k1, mix ^ k1 ^ k2,
                 mix ^ k1 ^ k2 ^ k3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_key   <= '0;
      cur_key    <= '0;
      dec_q      <= 1'b0;
      round      <= 4'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      last_round <= 1'b0;
    end else begin
      if (key_load) begin
        base_key <= key_in;
        cur_key  <= key_in;
        dec_q    <= dec;
        round    <= 4'd0;
      end else if (accept) begin
        if (round == LAST) begin
          round   <= 4'd0;
          cur_key <= base_key;
        end else begin
          round   <= round + 4'd1;
          cur_key <= nxt_key;
        end
      end
      if (accept) begin
        out_data   <= in_data ^ cur_key;
        out_valid  <= 1'b1;
        last_round <= (round == LAST);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
        last_round <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: known-answer table,
// corner sequences and random traffic against a key-schedule model.
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         dec;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   round;
  logic         last_round;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_round_key_stage dut (
    .clk(clk),
    .rst(rst),
    .key_load(key_load),
    .key_in(key_in),
    .dec(dec),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .round(round),
    .last_round(last_round)
  );

  logic [7:0]   sb [256];
  logic [127:0] m_keys [11];
  logic [127:0] m_od;
  logic         m_ov;
  logic         m_last;
  int           m_round;

  typedef struct {
    logic [127:0] key;
    logic         d;
    int           idx;
    logic [127:0] din;
    logic [127:0] rk;
    logic         last;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b,
                                      input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse then affine map.
  task automatic make_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
            ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Full 44-word schedule, built forward from the cipher key
  // or backward from the last round key; stored in use order.
  task automatic build(input logic [127:0] k, input logic d);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [11];
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = xt(rc[i-1]);
    if (!d) begin
      for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
      for (int i = 4; i < 44; i++) begin
        t = w[i-1];
        if (i % 4 == 0)
          t = subw({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
        w[i] = w[i-4] ^ t;
      end
    end else begin
      for (int j = 0; j < 4; j++) w[40+j] = k[127-32*j -: 32];
      for (int i = 43; i >= 4; i--) begin
        t = w[i-1];
        if (i % 4 == 0)
          t = subw({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
        w[i-4] = w[i] ^ t;
      end
    end
    for (int r = 0; r <= 10; r++)
      m_keys[d ? 10 - r : r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_ov    = 1'b0;
    m_od    = '0;
    m_last  = 1'b0;
    m_round = 0;
    build('0, 1'b0);
  endtask

  task automatic step(input logic kl, input logic [127:0] k,
                      input logic d, input logic iv,
                      input logic [127:0] din, input logic ordy);
    logic exp_ir;
    logic acc;
    @(negedge clk);
    key_load  = kl;
    key_in    = k;
    dec       = d;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    #1;
    exp_ir = !kl && (!m_ov || ordy);
    chk("in_ready", 128'(in_ready), 128'(exp_ir));
    acc = iv && exp_ir;
    @(posedge clk);
    if (acc) begin
      m_od    = din ^ m_keys[m_round];
      m_ov    = 1'b1;
      m_last  = (m_round == 10);
      m_round = (m_round == 10) ? 0 : m_round + 1;
    end else if (ordy) begin
      m_ov   = 1'b0;
      m_last = 1'b0;
    end
    if (kl) begin
      build(k, d);
      m_round = 0;
    end
    #1;
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("out_data", out_data, m_od);
    chk("last_round", 128'(last_round), 128'(m_last));
    chk("round", 128'(round), 128'(m_round));
  endtask

  localparam logic [127:0] K_ENC = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] k2;
    logic [127:0] d2;
    rst       = 1'b1;
    key_load  = 1'b0;
    key_in    = '0;
    dec       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    make_sbox();
    model_reset();

    vecs[0] = '{K_ENC, 1'b0, 0, '0, K_ENC, 1'b0};
    vecs[1] = '{K_ENC, 1'b0, 1, '0, K_R1, 1'b0};
    vecs[2] = '{K_ENC, 1'b0, 2, 128'h00112233445566778899aabbccddeeff,
                K_R2, 1'b0};
    vecs[3] = '{K_ENC, 1'b0, 10, '0, K_R10, 1'b1};
    vecs[4] = '{K_R10, 1'b1, 0, '0, K_R10, 1'b0};
    vecs[5] = '{K_R10, 1'b1, 1, 128'hffffffff00000000ffffffff00000000,
                K_R9, 1'b0};
    vecs[6] = '{K_R10, 1'b1, 9, '0, K_R1, 1'b0};
    vecs[7] = '{K_R10, 1'b1, 10, '0, K_ENC, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_last_round", 128'(last_round), 128'(0));
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      step(1'b1, vecs[v].key, vecs[v].d, 1'b0, '0, 1'b1);
      for (int b = 0; b <= vecs[v].idx; b++)
        step(1'b0, '0, 1'b0, 1'b1,
             (b == vecs[v].idx) ? vecs[v].din : '0, 1'b1);
      chk($sformatf("kat%0d_data", v), out_data,
          vecs[v].rk ^ vecs[v].din);
      chk($sformatf("kat%0d_last", v), 128'(last_round),
          128'(vecs[v].last));
      if (vecs[v].last)
        chk($sformatf("kat%0d_wrap", v), 128'(round), 128'(0));
    end

    // Backpressure after the first beat
    step(1'b1, K_ENC, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, '1, 1'b0);
    chk("bp_hold_data", out_data, K_ENC);
    chk("bp_hold_round", 128'(round), 128'(1));
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
    chk("bp_next_key", out_data, K_R1);
    chk("bp_round", 128'(round), 128'(2));
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Key load colliding with a beat at round 5
    step(1'b1, K_ENC, 1'b0, 1'b0, '0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0, 1'b1,
                    {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    chk("kl_round5", 128'(round), 128'(5));
    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    d2 = 128'h3243f6a8885a308d313198a2e0370734;
    step(1'b1, k2, 1'b0, 1'b1, '1, 1'b1);
    chk("kl_round0", 128'(round), 128'(0));
    step(1'b0, '0, 1'b0, 1'b1, d2, 1'b1);
    chk("kl_new_key", out_data, k2 ^ d2);

    // Asynchronous reset with a pending beat
    step(1'b1, K_ENC, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_round", 128'(round), 128'(0));
    chk("arst_out_data", out_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);

    repeat (600)
      step($urandom_range(0, 19) == 0,
           {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 9) < 7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
